// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo_ram block and its storage sub-module.
//   RAM_DISTRIBUTED / RAM_BLOCK : legal values of the RAM_STYLE parameter
//   count_width()               : width of an occupancy counter for a given
//                                 address width (must hold 0..depth inclusive)
//   thresholds_legal()          : parameter sanity check for the almost-full /
//                                 almost-empty thresholds (0..depth)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam string RAM_DISTRIBUTED = "distributed";
  localparam string RAM_BLOCK       = "block";

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit thresholds_legal(input int addr_width,
                                          input int afull_thresh,
                                          input int aempty_thresh);
    int depth;
    depth = 1 << addr_width;
    return (afull_thresh >= 0) && (afull_thresh <= depth) &&
           (aempty_thresh >= 0) && (aempty_thresh <= depth);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered output and a read enable. Contents are not reset; only the read
// data register is (so the FIFO output has a defined value after reset).
// A read and a write to the same address in the same cycle return the OLD
// word (read-first), which the FIFO relies on when it is full and both
// pushes and pops in one cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i write port
//   re_i/raddr_i        read request and address
//   rdata_o             registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module sdp_ram
  import fifo_pkg::*;
#(
  parameter string RAM_STYLE  = RAM_DISTRIBUTED,
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdata_q;

  // The storage array carries a literal ram_style attribute so that every
  // synthesis tool sees a constant string.
  if (RAM_STYLE == RAM_BLOCK) begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rd_word = mem[raddr_i];
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rd_word = mem[raddr_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Single-clock FIFO on an inferred simple dual-port RAM, with standard or
// first-word-fall-through read timing, occupancy count, programmable
// almost-full / almost-empty flags and sticky overflow / underflow flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, din        push request and data
//   full, almost_full occupancy == depth, occupancy >= AFULL_THRESH
//   rd_en, dout       pop request and data
//   empty             no word available to read
//   almost_empty      occupancy <= AEMPTY_THRESH
//   count             occupancy (accepted, not yet popped)
//   overflow          sticky: wr_en while full and not popping
//   underflow         sticky: rd_en while empty
//   clr_err           synchronous clear of overflow / underflow
//
// Handshake: a push is taken on a rising edge where wr_en=1 and either
// full=0 or a pop is taken on that same edge; a pop is taken where rd_en=1
// and empty=0. Requests that are not taken have no effect apart from the
// sticky error flags.
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter string RAM_STYLE     = RAM_DISTRIBUTED,
  parameter int    DATA_WIDTH    = 8,
  parameter int    ADDR_WIDTH    = 4,
  parameter int    FWFT          = 0,
  parameter int    AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int    AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int              DEPTH    = 1 << ADDR_WIDTH;
  localparam int              CW       = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_THRESH);

  if (!thresholds_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_ram: AFULL_THRESH/AEMPTY_THRESH must lie within 0..depth");
  end

  // State
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // Datapath control
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ram_re;
  logic [CW-1:0]         ram_words;

  always_comb begin
    rd_acc = rd_en && !empty_q;
    wr_acc = wr_en && (!full_q || rd_acc);

    // In FWFT mode the output register holds the head word and is part of
    // count; ram_words is what is still sitting in the RAM behind it.
    ram_words = count_q - CW'(dout_valid_q);

    if (FWFT != 0) begin
      // Refill the output register whenever it is free or being popped and
      // the RAM has a word; this gives back-to-back pops with no bubble.
      ram_re       = (ram_words != '0) && (!dout_valid_q || rd_acc);
      dout_valid_d = ram_re || (dout_valid_q && !rd_acc);
    end else begin
      ram_re       = rd_acc;
      dout_valid_d = 1'b0;
    end

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    // Flags are computed from next-state values so the registered flags
    // line up with the registered count every cycle.
    empty_d  = (FWFT != 0) ? !dout_valid_d : (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    // A new error in the clearing cycle wins over clr_err.
    ovf_d = (ovf_q && !clr_err) || (wr_en && full_q && !rd_en);
    unf_d = (unf_q && !clr_err) || (rd_en && empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      aempty_q     <= 1'b1;
      afull_q      <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      aempty_q     <= aempty_d;
      afull_q      <= afull_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // The RAM's registered read port doubles as the dout register in both
  // modes: standard mode loads it on a pop, FWFT mode on a prefetch.
  sdp_ram #(
    .RAM_STYLE  (RAM_STYLE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
